mul_div_unit: RTL and testbench

Sequential signed multiply/divide unit sitting beside the ALU in the datapath, between the Y register and the 64-bit Z register. It captures the operand in Y and the operand on the bus and runs a 32-iteration radix-2 Booth multiply or restoring divide. It then presents a 64-bit result in Zhigh/Zlow layout, so the control unit can latch it into Z and move it to HI/LO.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/div_step.sv | 31 +++
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 tb/tb_mul_div_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath definitions: opcode list and multiply/divide sequencer states.
// Imported by every datapath unit that decodes opcodes.
package cpu_pkg;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_MUL = 5'b10000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } md_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the control unit and mul_div_unit.
// master = control side, slave = the unit.
interface mul_div_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  logic [4:0]           opcode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic                 div0;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, opcode, a, b,
    input  busy, done, div0, result
  );

  modport slave (
    input  start, opcode, a, b,
    output busy, done, div0, result
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep it if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             take;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    take    = shifted >= {1'b0, divisor};
    // a kept difference is below the divisor, so WIDTH bits suffice
    trial   = shifted[WIDTH-1:0] - divisor;
    if (take) begin
      rem_next = trial;
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring) unit.
// 64-bit result in Zhigh/Zlow layout; 34 cycles from start to done.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic clear,
  mul_div_if.slave bus
);

  localparam int W = WIDTH;

  md_state_t state, state_n;

  logic [5:0]     cnt;
  logic           is_div;
  logic           a_neg;
  logic           b_neg;
  logic           b_zero;
  logic [W-1:0]   a_keep;
  logic [W:0]     acc;
  logic [W:0]     m;
  logic [W-1:0]   q;
  logic           q1;
  logic           div0_q;
  logic [2*W-1:0] result_q;

  logic           op_ok;
  logic           accept;
  logic           last;
  logic [W:0]     sum;
  logic [W-1:0]   rem_n;
  logic [W-1:0]   quo_n;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  always_comb begin
    op_ok = 1'b0;
    unique case (1'b1)
      bus.opcode == OP_MUL: op_ok = 1'b1;
      bus.opcode == OP_DIV: op_ok = 1'b1;
      default:              op_ok = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && bus.start && op_ok;
  assign last   = cnt == 6'(W-1);
  assign a_mag  = bus.a[W-1] ? -bus.a : bus.a;
  assign b_mag  = bus.b[W-1] ? -bus.b : bus.b;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (last) state_n = FIX;
      FIX:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Booth step; acc carries one guard bit so -2^(W-1) as multiplicand is safe
  always_comb begin
    sum = acc;
    unique case ({q[0], q1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  div_step #(.WIDTH(W)) u_div_step (
    .rem      (acc[W-1:0]),
    .quo      (q),
    .divisor  (m[W-1:0]),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  assign quo_fix = (a_neg ^ b_neg) ? -q : q;
  assign rem_fix = a_neg ? -acc[W-1:0] : acc[W-1:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      b_zero   <= 1'b0;
      a_keep   <= '0;
      acc      <= '0;
      m        <= '0;
      q        <= '0;
      q1       <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= bus.opcode == OP_DIV;
      a_neg  <= bus.a[W-1];
      b_neg  <= bus.b[W-1];
      b_zero <= bus.b == '0;
      a_keep <= bus.a;
      acc    <= '0;
      q1     <= 1'b0;
      div0_q <= 1'b0;
      if (bus.opcode == OP_DIV) begin
        q <= a_mag;
        m <= {1'b0, b_mag};
      end else begin
        q <= bus.b;
        m <= {bus.a[W-1], bus.a};
      end
    end else if (state == RUN) begin
      cnt <= cnt + 6'd1;
      if (is_div) begin
        acc <= {1'b0, rem_n};
        q   <= quo_n;
      end else begin
        acc <= {sum[W], sum[W:1]};
        q   <= {sum[0], q[W-1:1]};
        q1  <= q[0];
      end
    end else if (state == FIX) begin
      div0_q <= is_div && b_zero;
      if (!is_div)
        result_q <= {acc[W-1:0], q};
      else if (b_zero)
        result_q <= {a_keep, {W{1'b1}}};
      else
        result_q <= {rem_fix, quo_fix};
    end
  end

  assign bus.busy   = state != IDLE;
  assign bus.done   = state == DONE;
  assign bus.div0   = div0_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: products, quotients, div-by-zero,
// ignored requests, mid-operation clear and done latency.
module tb_mul_div_unit;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic clear = 1'b1;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  int          lat;
  logic [63:0] res;
  logic        d0;
  logic        d0_early;
  int          dones;

  task automatic run_op(input logic [4:0] op,
                        input logic [31:0] x,
                        input logic [31:0] y);
    int cyc;
    @(negedge clock);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.a      = x;
    bus.b      = y;
    @(negedge clock);
    bus.start = 1'b0;
    bus.a     = ~x;
    bus.b     = ~y;
    cyc       = 1;
    d0_early  = bus.div0;
    while (!bus.done && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    lat = cyc;
    res = bus.result;
    d0  = bus.div0;
    check("done_seen", 64'(bus.done), 64'd1);
    check("busy_in_done", 64'(bus.busy), 64'd1);
    @(negedge clock);
    check("idle_after", 64'({bus.busy, bus.done}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_div0", 64'(bus.div0), 64'd0);
    check("rst_result", bus.result, 64'd0);
    clear = 1'b0;
    @(negedge clock);

    run_op(OP_MUL, 32'd6, 32'd7);
    check("mul_6x7", res, 64'h0000_0000_0000_002A);
    check("mul_latency", 64'(lat), 64'd34);

    run_op(OP_MUL, -32'sd3, 32'd5);
    check("mul_m3x5", res, 64'hFFFF_FFFF_FFFF_FFF1);

    run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000);
    check("mul_min_min", res, 64'h4000_0000_0000_0000);

    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_m1_m1", res, 64'h0000_0000_0000_0001);

    run_op(OP_DIV, 32'd9, 32'd0);
    check("div_9_0", res, 64'h0000_0009_FFFF_FFFF);
    check("div0_set", 64'(d0), 64'd1);
    check("div0_latency", 64'(lat), 64'd34);

    run_op(OP_DIV, 32'd17, 32'd5);
    check("div0_cleared", 64'(d0_early), 64'd0);
    check("div_17_5", res, 64'h0000_0002_0000_0003);
    check("div_17_5_flag", 64'(d0), 64'd0);

    run_op(OP_DIV, -32'sd17, 32'd5);
    check("div_m17_5", res, 64'hFFFF_FFFE_FFFF_FFFD);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_m1", res, 64'h0000_0000_8000_0000);
    check("div_min_m1_flag", 64'(d0), 64'd0);

    // start while busy is ignored, result holds until FIX
    @(negedge clock);
    bus.start  = 1'b1;
    bus.opcode = OP_DIV;
    bus.a      = 32'd100;
    bus.b      = 32'd7;
    @(negedge clock);
    bus.start = 1'b0;
    dones     = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        check("result_hold", bus.result, 64'h0000_0000_8000_0000);
        bus.start  = 1'b1;
        bus.opcode = OP_MUL;
        bus.a      = 32'd2;
        bus.b      = 32'd3;
      end
      if (c == 6) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        res = bus.result;
      end
      @(negedge clock);
    end
    check("busy_ign_dones", 64'(dones), 64'd1);
    check("div_100_7", res, 64'h0000_0002_0000_000E);
    check("busy_ign_idle", 64'(bus.busy), 64'd0);

    bus.start  = 1'b1;
    bus.opcode = 5'b00011;
    @(negedge clock);
    check("bad_op_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    @(negedge clock);
    check("bad_op_idle", 64'({bus.busy, bus.done}), 64'd0);

    // clear in the middle of a divide
    bus.start  = 1'b1;
    bus.opcode = OP_DIV;
    bus.a      = 32'd1000;
    bus.b      = 32'd3;
    @(negedge clock);
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) @(negedge clock);
    check("pre_clear_busy", 64'(bus.busy), 64'd1);
    clear = 1'b1;
    #1;
    check("clr_busy", 64'(bus.busy), 64'd0);
    check("clr_done", 64'(bus.done), 64'd0);
    check("clr_result", bus.result, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) dones++;
      @(negedge clock);
    end
    check("clr_no_done", 64'(dones), 64'd0);

    run_op(OP_MUL, 32'd6, 32'd7);
    check("mul_after_clr", res, 64'h0000_0000_0000_002A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
